// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 memory responder.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
  localparam logic [31:0] DEF_STOP_PC         = 32'h0000_0018;
  localparam logic [31:0] DEF_CHECK_ADDR      = 32'h0000_0040;
  localparam logic [31:0] DEF_EXPECTED_RESULT = 32'h0000_0031;

  // Byte address falls inside a words-deep 32-bit array.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return addr < 32'(words * 4);
  endfunction

endpackage

// File: rtl/rv32_word_ram.sv
// Word array: one write port, one combinational read, one registered read-first read.
module rv32_word_ram #(
  parameter int WORDS = 32,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [31:0]   o_rdata_a,
  input  logic          i_rd_en,
  input  logic          i_rd_clr,
  input  logic [AW-1:0] i_raddr_b,
  output logic [31:0]   o_rdata_b
);

  // Contents deliberately survive reset so a rerun can skip reloading.
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata_b;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rdata_b <= '0;
    else if (i_rd_en) r_rdata_b <= i_rd_clr ? '0 : r_mem[i_raddr_b];
  end

  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/rv32_mem_responder.sv
// Memory slave for the RV32 core: loader front end, instruction/data ports, run monitor.
module rv32_mem_responder
  import rv32_mem_pkg::*;
#(
  parameter int          MEM_WORDS       = 32,
  parameter logic [31:0] STOP_PC         = DEF_STOP_PC,
  parameter logic [31:0] CHECK_ADDR      = DEF_CHECK_ADDR,
  parameter logic [31:0] EXPECTED_RESULT = DEF_EXPECTED_RESULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_data_o,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        err_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] CHK_IDX = CHECK_ADDR[AW+1:2];

  state_e        r_state;
  logic          r_core_rst, r_ready, r_done, r_pass, r_err;
  logic          w_ld_ok, w_i_ok, w_d_ok, w_ld_acc, w_in_run, w_we;
  logic [AW-1:0] w_waddr, w_raddr_a;
  logic [31:0]   w_wdata, w_rdata_a;

  assign w_ld_ok  = addr_in_range(load_addr_i, MEM_WORDS);
  assign w_i_ok   = addr_in_range(instr_addr_i, MEM_WORDS);
  assign w_d_ok   = addr_in_range(mem_addr_i, MEM_WORDS);
  assign w_in_run = (r_state == ST_RUN);
  assign w_ld_acc = (r_state == ST_LOAD) && load_valid_i && r_ready;

  assign w_we    = (w_ld_acc && w_ld_ok) || (w_in_run && mem_we_i && w_d_ok);
  assign w_waddr = (r_state == ST_LOAD) ? load_addr_i[AW+1:2] : mem_addr_i[AW+1:2];
  assign w_wdata = (r_state == ST_LOAD) ? load_data_i : mem_data_i;

  // The core is frozen during CHECK, so the fetch port is borrowed for the result word.
  assign w_raddr_a = (r_state == ST_CHECK) ? CHK_IDX : instr_addr_i[AW+1:2];

  rv32_word_ram #(.WORDS(MEM_WORDS)) u_ram (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_raddr_a),
    .o_rdata_a (w_rdata_a),
    .i_rd_en   (w_in_run),
    .i_rd_clr  (!w_d_ok),
    .i_raddr_b (mem_addr_i[AW+1:2]),
    .o_rdata_b (mem_data_o)
  );

  assign instr_data_o = w_i_ok ? w_rdata_a : NOP_INSTR;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_LOAD;
      r_core_rst <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_ready <= 1'b1;
          if (w_ld_acc && !w_ld_ok) r_err <= 1'b1;
          if (w_ld_acc && load_last_i) begin
            r_state    <= ST_RUN;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!w_i_ok || !w_d_ok) r_err <= 1'b1;
          if (instr_addr_i == STOP_PC) begin
            r_state    <= ST_CHECK;
            r_core_rst <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_pass  <= (w_rdata_a == EXPECTED_RESULT);
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: ;
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign core_rst_o   = r_core_rst;
  assign load_ready_o = r_ready;
  assign done_o       = r_done;
  assign pass_o       = r_pass;
  assign err_o        = r_err;

endmodule
